// File: rtl/interval_timer_sched_pkg.sv
// Shared types and helpers for the interval timer scheduler: FSM state encoding,
// terminal-count derivation and modulo pointer arithmetic.
package itsched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_e;

  // All-ones value of a w-bit counter, returned wide so callers can cast to their width.
  function automatic logic [63:0] term_of(input int unsigned w);
    return (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
  endfunction

  function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/interval_timer_sched_if.sv
// Requester-side bundle of the interval timer scheduler: level requests with start
// values in, grant/busy/completion reporting out.
interface interval_timer_sched_if #(
  parameter int W    = 4,
  parameter int NREQ = 4
);
  localparam int IW = $clog2(NREQ);

  logic [NREQ-1:0]   req;
  logic [NREQ*W-1:0] start_val;
  logic              abort;
  logic [NREQ-1:0]   gnt;
  logic              busy;
  logic              done;
  logic [IW-1:0]     done_id;

  modport master (
    output req, start_val, abort,
    input  gnt, busy, done, done_id
  );

  modport slave (
    input  req, start_val, abort,
    output gnt, busy, done, done_id
  );

endinterface

// File: rtl/interval_timer_sched_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first asserted request starting at ptr
// and wrapping modulo NREQ, reporting it both one-hot and as an index.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] onehot,
  output logic [IW-1:0]   idx,
  output logic            any
);

  int          cand;
  logic [IW-1:0] cand_idx;

  // The modulo keeps the search inside the request vector even when NREQ is not a power of two.
  always_comb begin
    onehot   = '0;
    idx      = '0;
    any      = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand     = (int'(ptr) + k) % NREQ;
      cand_idx = IW'(cand);
      if (!any && req[cand_idx]) begin
        any              = 1'b1;
        idx              = cand_idx;
        onehot[cand_idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/interval_timer_sched.sv
// Shares one loadable up-counter among NREQ requesters: grants round-robin, loads the
// winner's start value, lets the counter run to all-ones and reports the owner on done.
module interval_timer_sched
  import itsched_pkg::*;
#(
  parameter int W    = 4,
  parameter int NREQ = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  interval_timer_sched_if.slave  bus,
  output logic                   cnt_reset,
  output logic                   cnt_load,
  output logic [W-1:0]           cnt_data,
  input  logic [W-1:0]           cnt_q
);

  localparam int           IW   = $clog2(NREQ);
  localparam logic [W-1:0] TERM = W'(term_of(W));

  state_e          state_q, state_d;
  logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [IW-1:0]   done_id_q, done_id_d;
  logic [IW-1:0]   owner_q, owner_d;
  logic [W-1:0]    val_q, val_d;

  logic [NREQ-1:0] arb_onehot;
  logic [IW-1:0]   arb_idx;
  logic            arb_any;
  logic [W-1:0]    start_arr [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_start
    assign start_arr[g] = bus.start_val[g*W +: W];
  end

  rr_arbiter #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_arb (
    .req    (bus.req),
    .ptr    (rr_ptr_q),
    .onehot (arb_onehot),
    .idx    (arb_idx),
    .any    (arb_any)
  );

  // Arbitration only happens in IDLE, so requests raised while the counter is owned simply wait.
  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    gnt_d     = '0;
    done_id_d = done_id_q;
    owner_d   = owner_q;
    val_d     = val_q;
    case (state_q)
      IDLE: begin
        if (arb_any) begin
          gnt_d    = arb_onehot;
          owner_d  = arb_idx;
          val_d    = start_arr[arb_idx];
          rr_ptr_d = IW'(wrap_inc(32'(arb_idx), NREQ));
          state_d  = LOAD;
        end
      end
      LOAD: begin
        state_d = bus.abort ? IDLE : RUN;
      end
      RUN: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else if (cnt_q == TERM) begin
          state_d   = DONE;
          done_id_d = owner_q;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      rr_ptr_q  <= '0;
      gnt_q     <= '0;
      done_id_q <= '0;
      owner_q   <= '0;
      val_q     <= '0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      gnt_q     <= gnt_d;
      done_id_q <= done_id_d;
      owner_q   <= owner_d;
      val_q     <= val_d;
    end
  end

  // Counter controls depend on state alone; the counter is parked in reset outside an interval.
  assign cnt_reset   = (state_q == IDLE) || (state_q == DONE);
  assign cnt_load    = (state_q == LOAD);
  assign cnt_data    = val_q;

  assign bus.gnt     = gnt_q;
  assign bus.busy    = (state_q != IDLE);
  assign bus.done    = (state_q == DONE);
  assign bus.done_id = done_id_q;

endmodule

// File: tb/tb_interval_timer_sched.sv
// Bench for interval_timer_sched with a 4-bit loadable counter core; a timeline model
// predicts every output each cycle and directed scenarios pin key values.
module tb_interval_timer_sched;

  localparam int W     = 4;
  localparam int NREQ  = 4;
  localparam int TERMV = 15;

  logic         clk = 1'b0;
  logic         reset;
  logic         cnt_reset;
  logic         cnt_load;
  logic [W-1:0] cnt_data;
  logic [W-1:0] cnt_q;

  int n_cmp = 0;
  int n_err = 0;

  interval_timer_sched_if #(.W(W), .NREQ(NREQ)) bus ();

  interval_timer_sched #(.W(W), .NREQ(NREQ)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .cnt_reset (cnt_reset),
    .cnt_load  (cnt_load),
    .cnt_data  (cnt_data),
    .cnt_q     (cnt_q)
  );

  always #5 clk = ~clk;

  // Counter core: reset beats load beats increment, wrapping at all-ones.
  always_ff @(posedge clk) begin
    if (cnt_reset)     cnt_q <= '0;
    else if (cnt_load) cnt_q <= cnt_data;
    else               cnt_q <= cnt_q + 1'b1;
  end

  task automatic checkOutput(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Timeline model: an interval is described by its grant cycle, last RUN cycle and done cycle.
  int m_valid = 0;
  int m_active = 0;
  int m_ptr = 0;
  int m_last = 0;
  int m_owner = 0;
  int m_start = 0;
  int m_g = 0;
  int m_run_end = 0;
  int m_done = 0;
  int cyc = 0;

  task automatic compareCycle();
    int exp_gnt, exp_busy, exp_done, exp_id, exp_rst, exp_load;
    exp_gnt  = 0;
    exp_busy = 0;
    exp_done = 0;
    exp_id   = m_last;
    exp_rst  = 1;
    exp_load = 0;
    if (m_active != 0) begin
      exp_busy = 1;
      exp_rst  = 0;
      if (cyc == m_g) begin
        exp_gnt  = 1 << m_owner;
        exp_load = 1;
      end
      if (cyc == m_done) begin
        exp_done = 1;
        exp_id   = m_owner;
      end
    end
    checkOutput("gnt", int'(bus.gnt), exp_gnt);
    checkOutput("busy", int'(bus.busy), exp_busy);
    checkOutput("done", int'(bus.done), exp_done);
    checkOutput("done_id", int'(bus.done_id), exp_id);
    checkOutput("cnt_load", int'(cnt_load), exp_load);
    if (!(m_active != 0 && cyc == m_done))
      checkOutput("cnt_reset", int'(cnt_reset), exp_rst);
    if (m_active != 0 && cyc == m_g)
      checkOutput("cnt_data", int'(cnt_data), m_start);
    if (m_active != 0 && cyc > m_g && cyc <= m_run_end)
      checkOutput("cnt_q", int'(cnt_q), (m_start + cyc - m_g - 1) % (TERMV + 1));
  endtask

  task automatic advanceModel();
    int r, found, idx;
    r = int'(bus.req);
    found = -1;
    if (reset) begin
      m_valid  = 1;
      m_active = 0;
      m_ptr    = 0;
      m_last   = 0;
    end else if (m_valid != 0) begin
      if (m_active == 0) begin
        for (int k = 0; k < NREQ; k++) begin
          idx = (m_ptr + k) % NREQ;
          if (found < 0 && ((r >> idx) & 1) != 0) found = idx;
        end
        if (found >= 0) begin
          m_active  = 1;
          m_owner   = found;
          m_start   = (int'(bus.start_val) >> (found * W)) & TERMV;
          m_g       = cyc + 1;
          m_run_end = m_g + 1 + (TERMV - m_start);
          m_done    = m_run_end + 1;
          m_ptr     = (found + 1) % NREQ;
        end
      end else if (bus.abort && cyc >= m_g && cyc <= m_run_end) begin
        m_active = 0;
      end else if (cyc == m_done) begin
        m_active = 0;
        m_last   = m_owner;
      end
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (m_valid != 0) compareCycle();
      advanceModel();
      cyc++;
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic applyStimulus(input logic [NREQ-1:0] r, input logic [NREQ*W-1:0] sv,
                               input logic ab);
    bus.req       = r;
    bus.start_val = sv;
    bus.abort     = ab;
  endtask

  task automatic waitGnt(input int bound, output int g);
    int steps;
    g = 0;
    steps = 0;
    while (g == 0 && steps < bound) begin
      step();
      steps++;
      g = int'(bus.gnt);
    end
    if (g == 0) checkOutput("gnt_timeout", 0, 1);
  endtask

  task automatic waitDone(input int bound, output int steps);
    int d;
    d = 0;
    steps = 0;
    while (d == 0 && steps < bound) begin
      step();
      steps++;
      d = int'(bus.done);
    end
    if (d == 0) checkOutput("done_timeout", 0, 1);
  endtask

  task automatic pulseReset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    int g, n;
    reset = 1'b1;
    applyStimulus('0, '0, 1'b0);
    repeat (3) step();
    checkOutput("rst_busy", int'(bus.busy), 0);
    checkOutput("rst_gnt", int'(bus.gnt), 0);
    checkOutput("rst_cnt_reset", int'(cnt_reset), 1);
    checkOutput("rst_done_id", int'(bus.done_id), 0);
    checkOutput("rst_ptr", int'(dut.rr_ptr_q), 0);
    reset = 1'b0;
    step();

    $display("[TB] single request, start C");
    applyStimulus(4'b0001, 16'h000C, 1'b0);
    step();
    checkOutput("t1_gnt", int'(bus.gnt), 1);
    applyStimulus(4'b0000, 16'h000C, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step();
      checkOutput("t1_run_q", int'(cnt_q), 12 + i);
    end
    step();
    checkOutput("t1_done", int'(bus.done), 1);
    checkOutput("t1_done_id", int'(bus.done_id), 0);
    step();

    $display("[TB] two requesters, drop on grant, re-raise");
    pulseReset();
    applyStimulus(4'b0101, 16'h0F0F, 1'b0);
    waitGnt(6, g);
    checkOutput("t2_gnt_a", g, 1);
    checkOutput("t2_ptr_a", int'(dut.rr_ptr_q), 1);
    applyStimulus(4'b0100, 16'h0F0F, 1'b0);
    waitDone(8, n);
    waitGnt(6, g);
    checkOutput("t2_gnt_b", g, 4);
    checkOutput("t2_ptr_b", int'(dut.rr_ptr_q), 3);
    applyStimulus(4'b0001, 16'h0F0F, 1'b0);
    waitDone(8, n);
    waitGnt(6, g);
    checkOutput("t2_gnt_c", g, 1);
    checkOutput("t2_ptr_c", int'(dut.rr_ptr_q), 1);
    applyStimulus(4'b0000, 16'h0F0F, 1'b0);
    waitDone(8, n);

    $display("[TB] all requesters held, fairness");
    pulseReset();
    applyStimulus(4'b1111, 16'hEEEE, 1'b0);
    for (int i = 0; i < 5; i++) begin
      waitGnt(6, g);
      checkOutput("t3_gnt", g, 1 << (i % NREQ));
      waitDone(8, n);
      checkOutput("t3_done_id", int'(bus.done_id), i % NREQ);
    end
    applyStimulus(4'b0000, 16'hEEEE, 1'b0);

    $display("[TB] boundary start values");
    applyStimulus(4'b0010, 16'h00F0, 1'b0);
    waitGnt(6, g);
    checkOutput("t4_gnt_f", g, 2);
    applyStimulus(4'b0000, 16'h00F0, 1'b0);
    waitDone(8, n);
    checkOutput("t4_run_f", n - 1, 1);
    applyStimulus(4'b0010, 16'h0000, 1'b0);
    waitGnt(6, g);
    applyStimulus(4'b0000, 16'h0000, 1'b0);
    waitDone(30, n);
    checkOutput("t4_run_0", n - 1, 16);

    $display("[TB] abort mid-run and abort at terminal");
    applyStimulus(4'b0001, 16'h0002, 1'b0);
    waitGnt(6, g);
    applyStimulus(4'b0000, 16'h0002, 1'b0);
    repeat (3) step();
    checkOutput("t5_q_run3", int'(cnt_q), 4);
    applyStimulus(4'b0000, 16'h0002, 1'b1);
    step();
    checkOutput("t5_busy", int'(bus.busy), 0);
    checkOutput("t5_done", int'(bus.done), 0);
    checkOutput("t5_cnt_reset", int'(cnt_reset), 1);
    applyStimulus(4'b0000, 16'h0002, 1'b0);
    step();
    checkOutput("t5_done_after", int'(bus.done), 0);
    applyStimulus(4'b0001, 16'h000D, 1'b0);
    waitGnt(6, g);
    applyStimulus(4'b0000, 16'h000D, 1'b0);
    repeat (3) step();
    checkOutput("t5_q_term", int'(cnt_q), 15);
    applyStimulus(4'b0000, 16'h000D, 1'b1);
    step();
    checkOutput("t5_term_busy", int'(bus.busy), 0);
    checkOutput("t5_term_done", int'(bus.done), 0);
    applyStimulus(4'b0000, 16'h000D, 1'b0);
    step();
    checkOutput("t5_term_done_after", int'(bus.done), 0);

    $display("[TB] reset mid-run with pending request");
    applyStimulus(4'b0001, 16'h0000, 1'b0);
    waitGnt(6, g);
    applyStimulus(4'b0100, 16'h0000, 1'b0);
    repeat (2) step();
    reset = 1'b1;
    step();
    checkOutput("t6_busy", int'(bus.busy), 0);
    checkOutput("t6_gnt", int'(bus.gnt), 0);
    checkOutput("t6_done", int'(bus.done), 0);
    checkOutput("t6_ptr", int'(dut.rr_ptr_q), 0);
    checkOutput("t6_cnt_reset", int'(cnt_reset), 1);
    reset = 1'b0;
    step();
    checkOutput("t6_q_zero", int'(cnt_q), 0);
    checkOutput("t6_regrant", int'(bus.gnt), 4);
    applyStimulus(4'b0000, 16'h0000, 1'b0);
    waitDone(30, n);
    checkOutput("t6_done_id", int'(bus.done_id), 2);

    repeat (3) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    n_err++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
